// File: rtl/subneg_pkg.sv
// Shared types for the SUBNEG core: instruction-level states and bus access phases.
package subneg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        EXEC,
        WRITE,
        OUTPUT
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_RWAIT,
        PH_WDATA,
        PH_WHOLD
    } phase_e;

    localparam int DEFAULT_OUT_ADDR = 255;

endpackage

// File: rtl/subneg_bus_ctrl.sv
// Single-access sequencer for the multiplexed address/data bus.
// The address phase starts in the same cycle req rises, so back-to-back accesses leave no gap.
module subneg_bus_ctrl
    import subneg_pkg::*;
#(
    parameter int W       = 8,
    parameter int RD_WAIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [W-1:0] addr_i,
    input  logic [W-1:0] wdata_i,
    input  logic [W-1:0] bus_in_i,
    output logic         done_o,
    output logic [W-1:0] rdata_o,
    output logic         le_o,
    output logic         moe_o,
    output logic         mwe_o,
    output logic [W-1:0] bus_oe_o,
    output logic [W-1:0] bus_out_o
);

    localparam int CW = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data is consumed by the requester on the edge that ends the last wait cycle.
    assign rdata_o = bus_in_i;

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        done_o    = 1'b0;
        le_o      = 1'b0;
        moe_o     = 1'b0;
        mwe_o     = 1'b0;
        bus_oe_o  = '0;
        bus_out_o = '0;
        case (phase_q)
            PH_IDLE: begin
                if (req_i) begin
                    le_o      = 1'b1;
                    bus_oe_o  = '1;
                    bus_out_o = addr_i;
                    cnt_d     = CW'(1);
                    phase_d   = we_i ? PH_WDATA : PH_RWAIT;
                end
            end
            PH_RWAIT: begin
                moe_o = 1'b1;
                if (cnt_q == CW'(RD_WAIT)) begin
                    done_o  = 1'b1;
                    phase_d = PH_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PH_WDATA: begin
                mwe_o     = 1'b1;
                bus_oe_o  = '1;
                bus_out_o = wdata_i;
                phase_d   = PH_WHOLD;
            end
            PH_WHOLD: begin
                bus_oe_o  = '1;
                bus_out_o = wdata_i;
                done_o    = 1'b1;
                phase_d   = PH_IDLE;
            end
            default: phase_d = PH_IDLE;
        endcase
    end

endmodule

// File: rtl/subneg_core_p.sv
// SUBNEG one-instruction core: mem[B] <= mem[B]-mem[A], branch to C when the result "goes negative".
// Writes to OUT_ADDR are diverted to out_data; a taken branch onto itself halts the core.
module subneg_core_p
    import subneg_pkg::*;
#(
    parameter int W        = 8,
    parameter int RD_WAIT  = 1,
    parameter int SIGNED   = 0,
    parameter int OUT_ADDR = DEFAULT_OUT_ADDR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [W-1:0] bus_in,
    output logic [W-1:0] bus_out,
    output logic [W-1:0] bus_oe,
    output logic         le,
    output logic         moe,
    output logic         mwe,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         halted,
    output logic [W-1:0] pc
);

    state_e       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] addrA_q, addrA_d, addrB_q, addrB_d, addrC_q, addrC_d;
    logic [W-1:0] valA_q, valA_d, valB_q, valB_d;
    logic [W-1:0] res_q, res_d, outData_q, outData_d;
    logic         take_q, take_d, halted_q, halted_d, outValid_q, outValid_d;
    logic         req, we, done, finish;
    logic [W-1:0] addr, rdata, diff;

    subneg_bus_ctrl #(.W(W), .RD_WAIT(RD_WAIT)) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (res_q),
        .bus_in_i (bus_in),
        .done_o   (done),
        .rdata_o  (rdata),
        .le_o     (le),
        .moe_o    (moe),
        .mwe_o    (mwe),
        .bus_oe_o (bus_oe),
        .bus_out_o(bus_out)
    );

    assign diff = valB_q - valA_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            addrA_q    <= '0;
            addrB_q    <= '0;
            addrC_q    <= '0;
            valA_q     <= '0;
            valB_q     <= '0;
            res_q      <= '0;
            take_q     <= 1'b0;
            halted_q   <= 1'b0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addrA_q    <= addrA_d;
            addrB_q    <= addrB_d;
            addrC_q    <= addrC_d;
            valA_q     <= valA_d;
            valB_q     <= valB_d;
            res_q      <= res_d;
            take_q     <= take_d;
            halted_q   <= halted_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addrA_d    = addrA_q;
        addrB_d    = addrB_q;
        addrC_d    = addrC_q;
        valA_d     = valA_q;
        valB_d     = valB_q;
        res_d      = res_q;
        take_d     = take_q;
        halted_d   = halted_q;
        outData_d  = outData_q;
        outValid_d = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        addr       = '0;
        finish     = 1'b0;
        case (state_q)
            IDLE:    if (run && !halted_q) state_d = FETCH_A;
            FETCH_A: begin
                req  = 1'b1;
                addr = pc_q;
                if (done) begin addrA_d = rdata; state_d = FETCH_B; end
            end
            FETCH_B: begin
                req  = 1'b1;
                addr = pc_q + W'(1);
                if (done) begin addrB_d = rdata; state_d = FETCH_C; end
            end
            FETCH_C: begin
                req  = 1'b1;
                addr = pc_q + W'(2);
                if (done) begin addrC_d = rdata; state_d = READ_A; end
            end
            READ_A: begin
                req  = 1'b1;
                addr = addrA_q;
                if (done) begin valA_d = rdata; state_d = READ_B; end
            end
            READ_B: begin
                req  = 1'b1;
                addr = addrB_q;
                if (done) begin valB_d = rdata; state_d = EXEC; end
            end
            EXEC: begin
                res_d   = diff;
                take_d  = (SIGNED != 0) ? diff[W-1] : (valA_q > valB_q);
                state_d = (addrB_q == W'(OUT_ADDR)) ? OUTPUT : WRITE;
            end
            WRITE: begin
                req    = 1'b1;
                we     = 1'b1;
                addr   = addrB_q;
                finish = done;
            end
            OUTPUT: begin
                outData_d  = res_q;
                outValid_d = 1'b1;
                finish     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A taken branch back onto the same instruction can never make progress, so latch halt.
        if (finish) begin
            state_d  = IDLE;
            pc_d     = take_q ? addrC_q : pc_q + W'(3);
            halted_d = halted_q | (take_q && (addrC_q == pc_q));
        end
    end

    assign pc        = pc_q;
    assign halted    = halted_q;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_subneg_core_p.sv
// Self-checking bench for subneg_core_p: two instances (RD_WAIT=1 unsigned, RD_WAIT=3 signed)
// each with a behavioural memory; expected writes/outputs go through a scoreboard queue.
module tb_subneg_core_p;
   localparam int W = 8;

   typedef struct packed {
      logic         isOut;
      logic [W-1:0] addr;
      logic [W-1:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         run      [2];
   logic [W-1:0] busIn    [2];
   logic [W-1:0] busOut   [2];
   logic [W-1:0] busOe    [2];
   logic [W-1:0] outData  [2];
   logic [W-1:0] pcO      [2];
   logic [W-1:0] lat      [2];
   logic         le       [2];
   logic         moe      [2];
   logic         mwe      [2];
   logic         outValid [2];
   logic         halted   [2];
   logic [W-1:0] mem0 [256];
   logic [W-1:0] mem1 [256];

   exp_t expQ[$];
   int   vecCount = 0;
   int   missCount = 0;
   int   mweCycles, outCycles, readRuns, badRuns, tailAct, protoErr, latency;
   bit   ended;

   always #5 clk = ~clk;

   subneg_core_p #(.W(W), .RD_WAIT(1), .SIGNED(0), .OUT_ADDR(255)) u0 (
      .clk(clk), .rst_n(rst_n), .run(run[0]), .bus_in(busIn[0]), .bus_out(busOut[0]),
      .bus_oe(busOe[0]), .le(le[0]), .moe(moe[0]), .mwe(mwe[0]), .out_data(outData[0]),
      .out_valid(outValid[0]), .halted(halted[0]), .pc(pcO[0])
   );

   subneg_core_p #(.W(W), .RD_WAIT(3), .SIGNED(1), .OUT_ADDR(255)) u1 (
      .clk(clk), .rst_n(rst_n), .run(run[1]), .bus_in(busIn[1]), .bus_out(busOut[1]),
      .bus_oe(busOe[1]), .le(le[1]), .moe(moe[1]), .mwe(mwe[1]), .out_data(outData[1]),
      .out_valid(outValid[1]), .halted(halted[1]), .pc(pcO[1])
   );

   // External address latch and read-only memory model for both instances
   always @(posedge clk) begin
      if (le[0]) lat[0] <= busOut[0];
      if (le[1]) lat[1] <= busOut[1];
   end

   assign busIn[0] = moe[0] ? mem0[lat[0]] : '0;
   assign busIn[1] = moe[1] ? mem1[lat[1]] : '0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic pushExp(input logic isOut, input logic [W-1:0] a, input logic [W-1:0] d);
      exp_t e;
      e.isOut = isOut;
      e.addr  = a;
      e.data  = d;
      expQ.push_back(e);
   endtask

   task automatic popCheck(input logic isOut, input logic [W-1:0] a, input logic [W-1:0] d);
      exp_t e;
      checkOutput("sbHasEntry", 32'(expQ.size() != 0), 1);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      checkOutput("eventKind", 32'(isOut), 32'(e.isOut));
      if (isOut) begin
         checkOutput("outData", d, e.data);
      end else begin
         checkOutput("wrAddr", a, e.addr);
         checkOutput("wrData", d, e.data);
      end
   endtask

   task automatic doReset();
      rst_n  = 1'b0;
      run[0] = 1'b0;
      run[1] = 1'b0;
      expQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic loadInstr(input int i, input logic [W-1:0] base, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic [W-1:0] va, input logic [W-1:0] vb);
      if (i == 0) begin
         mem0[base] = a; mem0[base + 8'd1] = b; mem0[base + 8'd2] = c;
         mem0[a] = va; mem0[b] = vb;
      end else begin
         mem1[base] = a; mem1[base + 8'd1] = b; mem1[base + 8'd2] = c;
         mem1[a] = va; mem1[b] = vb;
      end
   endtask

   // Runs one instruction on instance i, monitoring the bus each cycle; drops run dropAt
   // cycles after the first address phase (never if negative), then watches tail idle cycles.
   task automatic applyStimulus(input int i, input int dropAt, input int tail);
      bit           started, prevMwe;
      int           t0, endK, moeRun, rdw;
      logic [W-1:0] pc0;
      mweCycles = 0; outCycles = 0; readRuns = 0; badRuns = 0;
      tailAct = 0; protoErr = 0; latency = -1;
      started = 0; ended = 0; prevMwe = 0; t0 = 0; endK = 0; moeRun = 0;
      rdw = (i == 0) ? 1 : 3;
      pc0 = pcO[i];
      run[i] = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if ((le[i] && moe[i]) || (moe[i] && mwe[i]) || (moe[i] && busOe[i] != '0)) protoErr++;
         if (moe[i]) moeRun++;
         else if (moeRun != 0) begin
            readRuns++;
            if (moeRun != rdw) badRuns++;
            moeRun = 0;
         end
         if (mwe[i]) begin
            mweCycles++;
            if (!prevMwe) popCheck(1'b0, lat[i], busOut[i]);
         end
         prevMwe = mwe[i];
         if (outValid[i]) begin
            outCycles++;
            popCheck(1'b1, '0, outData[i]);
         end
         if (ended) begin
            if (le[i] || moe[i] || mwe[i]) tailAct++;
            if (k - endK >= tail) break;
         end else if (!started) begin
            if (le[i]) begin started = 1; t0 = k; end
         end else begin
            if (k - t0 == dropAt) run[i] = 1'b0;
            if (pcO[i] != pc0 || halted[i]) begin
               ended = 1; endK = k; latency = k - t0;
            end
         end
      end
      checkOutput("instrEnd", 32'(ended), 1);
   endtask

   task automatic checkRun(input int i, input int expLat, input logic [W-1:0] expPc,
                           input int expMwe, input int expOut);
      checkOutput("latency", latency, expLat);
      checkOutput("pc", pcO[i], expPc);
      checkOutput("mweCycles", mweCycles, expMwe);
      checkOutput("outValidCycles", outCycles, expOut);
      checkOutput("protocol", protoErr, 0);
      checkOutput("readCount", readRuns, 5);
      checkOutput("readWidth", badRuns, 0);
      checkOutput("idleAfter", tailAct, 0);
      checkOutput("sbLeft", expQ.size(), 0);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      run[0] = 1'b0;
      run[1] = 1'b0;
      for (int a = 0; a < 256; a++) begin mem0[a] = '0; mem1[a] = '0; end

      // Reset held with run asserted: everything quiet
      run[0] = 1'b1;
      run[1] = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rstPc", pcO[0], 0);
      checkOutput("rstBus0", {le[0], moe[0], mwe[0], busOe[0], busOut[0]}, 0);
      checkOutput("rstOut0", {outValid[0], halted[0], outData[0]}, 0);
      checkOutput("rstBus1", {le[1], moe[1], mwe[1], busOe[1], busOut[1], pcO[1]}, 0);
      doReset();

      // No branch: 5-3 = 2 written to 11
      loadInstr(0, 0, 10, 11, 6, 8'd3, 8'd5);
      pushExp(1'b0, 8'd11, 8'd2);
      applyStimulus(0, 1, 5);
      checkRun(0, 14, 8'd3, 1, 0);

      // Equal operands: result 0, no branch
      doReset();
      loadInstr(0, 0, 10, 11, 6, 8'd5, 8'd5);
      pushExp(1'b0, 8'd11, 8'd0);
      applyStimulus(0, 1, 5);
      checkRun(0, 14, 8'd3, 1, 0);

      // Unsigned branch: 5-7 = 0xFE, jump to 6
      doReset();
      loadInstr(0, 0, 10, 11, 6, 8'd7, 8'd5);
      pushExp(1'b0, 8'd11, 8'hFE);
      applyStimulus(0, 1, 5);
      checkRun(0, 14, 8'd6, 1, 0);
      checkOutput("noHalt", halted[0], 0);

      // Output port: 9-4 = 5 to out_data, no memory write
      doReset();
      loadInstr(0, 0, 4, 255, 0, 8'd4, 8'd9);
      pushExp(1'b1, 8'd255, 8'd5);
      applyStimulus(0, 1, 5);
      checkRun(0, 12, 8'd3, 0, 1);
      checkOutput("outDataHeld", outData[0], 8'd5);

      // Halt: advance to pc=3, then a taken branch onto itself
      doReset();
      loadInstr(0, 0, 12, 13, 6, 8'd1, 8'd5);
      pushExp(1'b0, 8'd13, 8'd4);
      applyStimulus(0, 1, 2);
      checkOutput("prePc", pcO[0], 8'd3);
      loadInstr(0, 3, 10, 11, 3, 8'd7, 8'd5);
      pushExp(1'b0, 8'd11, 8'hFE);
      applyStimulus(0, -1, 50);
      checkRun(0, 14, 8'd3, 1, 0);
      checkOutput("halted", halted[0], 1);
      run[0] = 1'b0;

      // Signed branch: 0x05-0x85 = 0x80 negative
      doReset();
      loadInstr(1, 0, 10, 11, 6, 8'h85, 8'h05);
      pushExp(1'b0, 8'd11, 8'h80);
      applyStimulus(1, 1, 5);
      checkRun(1, 24, 8'd6, 1, 0);

      // Signed no-branch where unsigned would branch: 0x05-0xFF = 0x06
      doReset();
      loadInstr(1, 0, 10, 11, 6, 8'hFF, 8'h05);
      pushExp(1'b0, 8'd11, 8'h06);
      applyStimulus(1, 1, 5);
      checkRun(1, 24, 8'd3, 1, 0);

      // RD_WAIT=3, run dropped mid-instruction, output instruction then pause
      doReset();
      loadInstr(1, 0, 4, 255, 0, 8'd4, 8'd9);
      pushExp(1'b1, 8'd255, 8'd5);
      applyStimulus(1, 3, 20);
      checkRun(1, 22, 8'd3, 0, 1);
      seen = 0;
      run[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (le[1]) begin seen = 1; break; end
      end
      checkOutput("resume", 32'(seen), 1);
      run[1] = 1'b0;

      // Asynchronous reset in the middle of a write
      doReset();
      loadInstr(0, 0, 10, 11, 6, 8'd3, 8'd5);
      run[0] = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mwe[0]) begin seen = 1; break; end
      end
      checkOutput("mweSeen", 32'(seen), 1);
      #1 rst_n = 1'b0;
      #1 checkOutput("asyncRst", {mwe[0], le[0], moe[0], busOe[0], busOut[0], pcO[0]}, 0);
      run[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/subneg_core_p.md
Name: subneg_core_p

Overview:
Parametrised SUBNEG one-instruction CPU core driving external memory over a multiplexed address/data bus (address latch strobe, output enable, write enable). Executes the full instruction: fetch A, B, C; read mem[A], mem[B]; write mem[B]-mem[A]; branch.
Adds configurable width, read wait states, signed/unsigned branch mode, a memory-mapped output port, run/pause and halt detection.
Sits directly under the top-level pad wrapper, which maps its bus onto the bidirectional pins.

Parameters:
W, 8, address and data width (shared bus; memory depth 2^W words)
RD_WAIT, 1, cycles moe is held before read data is sampled (>=1)
SIGNED, 0, 0: branch when valA > valB unsigned; 1: branch when (valB-valA) is negative two's-complement
OUT_ADDR, 255, addrB value that redirects the result to out_data instead of memory

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = execute; sampled only at instruction boundary (state FETCH_A entry)
bus_in  in  W  read data from external memory
bus_out  out  W  address (le phase) or write data
bus_oe  out  W  per-bit output enable, all-ones or all-zeros
le  out  1  address latch enable, active high
moe  out  1  memory output enable, active high
mwe  out  1  memory write enable, active high
out_data  out  W  last result written to OUT_ADDR
out_valid  out  1  one-cycle pulse when out_data updates
halted  out  1  sticky: self-loop branch detected
pc  out  W  current program counter

Behaviour:
- Reset (async, rst_n=0): pc=0, le=moe=mwe=0, bus_oe=0, bus_out=0, out_data=0, out_valid=0, halted=0, state=IDLE. Takes effect immediately, including mid-write (mwe drops asynchronously).
- IDLE: if run=1 and halted=0 -> FETCH_A next cycle; else stay, bus quiet (le=moe=mwe=0, bus_oe=0).
- Read access (addr X), 1+RD_WAIT cycles: cycle 0 le=1, bus_oe=all-ones, bus_out=X, moe=0; cycles 1..RD_WAIT le=0, moe=1, bus_oe=0; bus_in sampled on clock edge ending the last wait cycle.
- Write access (addr X, data D), 3 cycles: c0 le=1, bus_out=X, bus_oe=ones; c1 le=0, bus_out=D, mwe=1; c2 mwe=0, D still driven (hold); then bus_oe=0.
- Sequence: FETCH_A(pc) -> FETCH_B(pc+1) -> FETCH_C(pc+2) -> READ_A(addrA) -> READ_B(addrB) -> EXEC -> WRITE or OUTPUT -> IDLE. pc+1/pc+2 wrap mod 2^W.
- EXEC (1 cycle): res = valB - valA truncated to W bits; take = (SIGNED ? res[W-1] : valA > valB).
- OUTPUT (addrB==OUT_ADDR): 1 cycle, out_data<=res, out_valid=1 that cycle only; no mwe.
- Instruction-end edge: pc <= take ? addrC : pc+3 (mod 2^W). If take and addrC==pc: halted<=1, pc unchanged, stays in IDLE until reset.
- Latency, RD_WAIT=1: 14 cycles FETCH_A entry to IDLE with write; 12 with OUTPUT.
- Never le&moe, moe&mwe or moe with bus_oe nonzero in the same cycle.
- run deassert mid-instruction: instruction completes, then pauses in IDLE.

Decomposition:
- Package subneg_pkg: state enum (IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, EXEC, WRITE, OUTPUT), access-phase enum, default OUT_ADDR constant.
- Sub-module subneg_bus_ctrl: single-access sequencer (req, we, addr, wdata -> done, rdata, le/moe/mwe/bus_oe/bus_out), parametrised W, RD_WAIT. Core FSM issues one req per state.

Test Plan:
- Reset: hold rst_n=0 with run=1 -> all outputs 0, pc=0; assert rst_n=0 asynchronously mid-cycle -> outputs clear before next edge.
- No branch: mem[0..2]={10,11,6}, mem[10]=3, mem[11]=5 -> write 2 to addr 11 (mwe one cycle), pc=3, 14 cycles.
- Branch unsigned: mem[10]=7, mem[11]=5 -> mem[11]=0xFE, pc=6; SIGNED=1 with mem[10]=0x85(-123), mem[11]=0x05 -> res=0x80, pc=6.
- Output port: instr {4,255,0} at 0, mem[4]=4, mem[255]=9 -> out_data=5, out_valid one cycle, mwe never high, pc=3, 12 cycles.
- Halt: at pc=3 instr {10,11,3} with branch taken -> halted=1 after instruction, no further le/moe/mwe for 50 cycles.
- RD_WAIT=3, run dropped mid-instruction -> moe held 3 cycles per read, 22-cycle instruction completes, core stays in IDLE until run=1.
